tcp_tx_framer: RTL and testbench
================================

TCP_TX_FRAMER -- requirements
Module: tcp_tx_framer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 64 (range 1..65535): number of 32-bit payload words per frame.
REQ-002 SHALL have port clk, input, 1: single clock, same domain as the SiTCP core CLK (sys_clk, 250 MHz).
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: framing enable.
REQ-005 SHALL have port in_valid, input, 1: upstream word valid.
REQ-006 SHALL have port in_data, input, 32: upstream word.
REQ-007 SHALL have port in_ready, output, 1: upstream word accept.
REQ-008 SHALL have port tcp_open_ack, input, 1: connection established (from SiTCP TCP_OPEN_ACK).
REQ-009 SHALL have port tcp_tx_full, input, 1: SiTCP TX almost-full flag.
REQ-010 SHALL have port tcp_tx_wr, output, 1: byte write strobe to TCP_TX_WR.
REQ-011 SHALL have port tcp_txd, output, 8: byte to TCP_TX_DATA.
REQ-012 SHALL have port frame_cnt, output, 32: completed-frame count.
REQ-013 SHALL have port abort_cnt, output, 16: aborted-frame count.

Function
REQ-014 SHALL use states IDLE, HDR, PAYLOAD.
REQ-015 IDLE->HDR SHALL occur when enable, tcp_open_ack and in_valid are all high; there is no word accept in that cycle.
REQ-016 HDR SHALL emit the bytes 0xA5, 0x5A, FRAME_WORDS[15:8], FRAME_WORDS[7:0], in that order; the state then moves to PAYLOAD.
REQ-017 A byte SHALL be issued only in a cycle where tcp_tx_full is low; tcp_tx_wr and tcp_txd are registered, so they appear one cycle after that decision.
REQ-018 tcp_tx_wr SHALL be low in every cycle in which no byte is issued; tcp_txd SHALL then hold its last value.
REQ-019 In PAYLOAD the block SHALL hold a 32-bit shift register and a bytes_left count of 0..4.
REQ-020 in_ready SHALL be high only in PAYLOAD with words_sent < FRAME_WORDS and either bytes_left==0, or bytes_left==1 with tcp_tx_full low.
REQ-021 A word SHALL be accepted on in_valid && in_ready and emitted MSB first (big-endian).
REQ-022 Sustained throughput SHALL be one byte per clock while tcp_tx_full is low and in_valid is high.
REQ-023 In-frame starvation (in_valid low) SHALL insert no bytes and no padding.
REQ-024 After the last byte of word FRAME_WORDS, frame_cnt SHALL increment (wrapping at 2^32) and the state SHALL return to IDLE, which lasts at least one cycle.
REQ-025 enable falling mid-frame SHALL have no effect on the current frame; the frame completes normally and no new frame starts.
REQ-026 tcp_open_ack low in HDR or PAYLOAD SHALL cause, in the same cycle: state to IDLE, shift register flushed, in_ready low, no further bytes, and abort_cnt +1 (saturating at 0xFFFF).
REQ-027 tcp_open_ack and the final byte occurring together SHALL count as an abort, not a completion.
REQ-028 tcp_tx_full high SHALL stall all counters with no data loss.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE; tcp_tx_wr=0; tcp_txd=0x00; in_ready=0; frame_cnt=0; abort_cnt=0; sequence number=0; shift register and bytes_left cleared.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame and SHALL NOT increment abort_cnt.

Configuration
REQ-031 With macro TCP_TX_FRAMER_SEQ_EN defined, HDR SHALL append a 32-bit big-endian frame sequence number after the length bytes (8-byte header).
REQ-032 The sequence number SHALL start at 0 and increment on each completed frame and each aborted frame.
REQ-033 Without TCP_TX_FRAMER_SEQ_EN, the header SHALL be 4 bytes and no sequence register SHALL exist.

Structure
REQ-034 Package tcp_tx_pkg SHALL hold: the state enum; constants MAGIC0=0xA5, MAGIC1=0x5A; HDR_LEN (4 or 8 under the macro).
REQ-035 Sub-module tcp_tx_byte_ser SHALL implement the 32-to-8 shift register, bytes_left and the full-gated issue logic; the top holds the FSM and counters.

Verification
REQ-036 FRAME_WORDS=2, open, never full, words 0x01020304 and 0x05060708 -> bytes A5 5A 00 02 01 02 03 04 05 06 07 08 on 12 consecutive cycles; frame_cnt=1.
REQ-037 Same stimulus with tcp_tx_full high for 3 cycles mid-payload -> identical byte order, tcp_tx_wr gaps of 3 cycles, no lost or duplicated bytes.
REQ-038 tcp_open_ack dropped after 6 bytes -> no further tcp_tx_wr, abort_cnt=1, frame_cnt=0; reopen -> the next frame starts with A5.
REQ-039 With TCP_TX_FRAMER_SEQ_EN, 3 frames sent -> headers carry sequence 00000000, 00000001, 00000002.
REQ-040 rst pulsed mid-payload -> all outputs 0 immediately, abort_cnt stays 0, the next frame is well-formed.

Source files
------------

// File: rtl/tcp_tx_pkg.sv
// Shared types and constants for the SiTCP transmit framer.
// Header length depends on the optional TCP_TX_FRAMER_SEQ_EN build macro.
package tcp_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPayload
    } state_e;

    localparam logic [7:0] MAGIC0 = 8'hA5;
    localparam logic [7:0] MAGIC1 = 8'h5A;

`ifdef TCP_TX_FRAMER_SEQ_EN
    localparam int unsigned HDR_LEN = 8;
`else
    localparam int unsigned HDR_LEN = 4;
`endif

endpackage

// File: rtl/tcp_tx_byte_ser.sv
// 32-to-8 big-endian serializer with full-gated byte issue and registered byte outputs.
// Header bytes from the FSM share the same issue path as payload bytes.
module tcp_tx_byte_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hdr_vld,
    input  logic [7:0]  hdr_byte,
    input  logic        load_ok,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        tcp_tx_full,
    output logic        in_ready,
    output logic        accept,
    output logic        issue,
    output logic        last_byte,
    output logic        tcp_tx_wr,
    output logic [7:0]  tcp_txd
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  bytes_left_q, bytes_left_d;
    logic        wr_q, wr_d;
    logic [7:0]  txd_q, txd_d;
    logic        have_byte;
    logic [7:0]  out_byte;

    always_comb begin
        have_byte = (bytes_left_q != 3'd0);
        in_ready  = load_ok && !flush &&
                    ((bytes_left_q == 3'd0) || ((bytes_left_q == 3'd1) && !tcp_tx_full));
        accept    = in_valid && in_ready;
        // A word accepted into an empty register issues its MSB in the same cycle.
        issue     = !tcp_tx_full && !flush && (hdr_vld || have_byte || accept);
        last_byte = issue && (bytes_left_q == 3'd1);

        if (hdr_vld) begin
            out_byte = hdr_byte;
        end else if (have_byte) begin
            out_byte = shift_q[31:24];
        end else begin
            out_byte = in_data[31:24];
        end

        wr_d  = issue;
        txd_d = issue ? out_byte : txd_q;

        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        if (flush) begin
            shift_d      = '0;
            bytes_left_d = '0;
        end else if (accept) begin
            if (!have_byte && !tcp_tx_full) begin
                shift_d      = {in_data[23:0], 8'h00};
                bytes_left_d = 3'd3;
            end else begin
                shift_d      = in_data;
                bytes_left_d = 3'd4;
            end
        end else if (issue && have_byte) begin
            shift_d      = {shift_q[23:0], 8'h00};
            bytes_left_d = bytes_left_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bytes_left_q <= '0;
            wr_q         <= 1'b0;
            txd_q        <= 8'h00;
        end else begin
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            wr_q         <= wr_d;
            txd_q        <= txd_d;
        end
    end

    assign tcp_tx_wr = wr_q;
    assign tcp_txd   = txd_q;

endmodule

// File: rtl/tcp_tx_framer.sv
// Frames a 32-bit word stream into SiTCP TX bytes: magic, length, payload.
// Define TCP_TX_FRAMER_SEQ_EN to append a 32-bit frame sequence number to the header.
module tcp_tx_framer
    import tcp_tx_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        tcp_open_ack,
    input  logic        tcp_tx_full,
    output logic        tcp_tx_wr,
    output logic [7:0]  tcp_txd,
    output logic [31:0] frame_cnt,
    output logic [15:0] abort_cnt
);

    localparam logic [15:0] FrameLen = 16'(FRAME_WORDS);
    localparam logic [2:0]  HdrLast  = 3'(HDR_LEN - 1);

    state_e      state_q, state_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] words_sent_q, words_sent_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;
`ifdef TCP_TX_FRAMER_SEQ_EN
    logic [31:0] seq_q, seq_d;
`endif

    logic       flush, hdr_vld, load_ok;
    logic       accept, issue, last_byte, done;
    logic [7:0] hdr_byte;

    always_comb begin
        flush   = (state_q != StIdle) && !tcp_open_ack;
        hdr_vld = (state_q == StHdr);
        load_ok = (state_q == StPayload) && (words_sent_q < FrameLen);
        done    = (state_q == StPayload) && last_byte && (words_sent_q == FrameLen);
    end

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_byte = MAGIC0;
            3'd1:    hdr_byte = MAGIC1;
            3'd2:    hdr_byte = FrameLen[15:8];
            3'd3:    hdr_byte = FrameLen[7:0];
`ifdef TCP_TX_FRAMER_SEQ_EN
            3'd4:    hdr_byte = seq_q[31:24];
            3'd5:    hdr_byte = seq_q[23:16];
            3'd6:    hdr_byte = seq_q[15:8];
            3'd7:    hdr_byte = seq_q[7:0];
`endif
            default: hdr_byte = 8'h00;
        endcase
    end

    tcp_tx_byte_ser u_byte_ser (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .hdr_vld     (hdr_vld),
        .hdr_byte    (hdr_byte),
        .load_ok     (load_ok),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .tcp_tx_full (tcp_tx_full),
        .in_ready    (in_ready),
        .accept      (accept),
        .issue       (issue),
        .last_byte   (last_byte),
        .tcp_tx_wr   (tcp_tx_wr),
        .tcp_txd     (tcp_txd)
    );

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        words_sent_d = words_sent_q;
        frame_cnt_d  = frame_cnt_q;
        abort_cnt_d  = abort_cnt_q;
`ifdef TCP_TX_FRAMER_SEQ_EN
        seq_d        = seq_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable && tcp_open_ack && in_valid) begin
                    state_d      = StHdr;
                    hdr_idx_d    = 3'd0;
                    words_sent_d = 16'd0;
                end
            end
            StHdr, StPayload: begin
                // A dropped connection wins over a completing last byte.
                if (flush) begin
                    state_d = StIdle;
                    if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
`ifdef TCP_TX_FRAMER_SEQ_EN
                    seq_d = seq_q + 32'd1;
`endif
                end else if (state_q == StHdr) begin
                    if (issue) begin
                        if (hdr_idx_q == HdrLast) state_d = StPayload;
                        else hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end else begin
                    if (accept) words_sent_d = words_sent_q + 16'd1;
                    if (done) begin
                        state_d     = StIdle;
                        frame_cnt_d = frame_cnt_q + 32'd1;
`ifdef TCP_TX_FRAMER_SEQ_EN
                        seq_d = seq_q + 32'd1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hdr_idx_q    <= 3'd0;
            words_sent_q <= 16'd0;
            frame_cnt_q  <= 32'd0;
            abort_cnt_q  <= 16'd0;
`ifdef TCP_TX_FRAMER_SEQ_EN
            seq_q        <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            words_sent_q <= words_sent_d;
            frame_cnt_q  <= frame_cnt_d;
            abort_cnt_q  <= abort_cnt_d;
`ifdef TCP_TX_FRAMER_SEQ_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_tcp_tx_framer.sv
// Self-checking bench for tcp_tx_framer: byte stream compared against a frame-level model.
module tb_tcp_tx_framer;

    localparam int unsigned FW = 2;
`ifdef TCP_TX_FRAMER_SEQ_EN
    localparam int HL = 8;
`else
    localparam int HL = 4;
`endif
    localparam int FL = HL + 4 * FW;

    logic        clk = 1'b0;
    logic        rst, enable, in_valid, in_ready, tcp_open_ack, tcp_tx_full, tcp_tx_wr;
    logic [31:0] in_data, frame_cnt;
    logic [7:0]  tcp_txd;
    logic [15:0] abort_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int full_viol = 0;
    bit full_hist [1024];
    logic [7:0]  cap_b[$];
    int          cap_c[$];
    logic [7:0]  exp_b[$];
    logic [31:0] words[$];
    int          wptr = 0;
    int unsigned seq_m = 0;
    int unsigned exp_frames = 0;

    tcp_tx_framer #(.FRAME_WORDS(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .tcp_open_ack (tcp_open_ack),
        .tcp_tx_full  (tcp_tx_full),
        .tcp_tx_wr    (tcp_tx_wr),
        .tcp_txd      (tcp_txd),
        .frame_cnt    (frame_cnt),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        full_hist[cyc % 1024] <= tcp_tx_full;
        cyc <= cyc + 1;
    end

    // A byte seen now was decided at the previous edge, where full must have been low.
    always @(negedge clk) begin
        if (!rst && tcp_tx_wr) begin
            cap_b.push_back(tcp_txd);
            cap_c.push_back(cyc);
            if (full_hist[(cyc - 1) % 1024]) full_viol++;
        end
    end

    task automatic drive(input bit v, input bit f);
        tcp_tx_full = f;
        in_valid    = v && (wptr < words.size());
        in_data     = (wptr < words.size()) ? words[wptr] : 32'h0;
        #1;
        if (in_valid && in_ready) wptr++;
    endtask

    task automatic tick(input bit v, input bit f);
        @(negedge clk);
        #1;
        drive(v, f);
    endtask

    task automatic new_words(input int n);
        words.delete();
        wptr = 0;
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic clear_cap;
        cap_b.delete();
        cap_c.delete();
        exp_b.delete();
    endtask

    // Reference frame: magic, 16-bit length, optional sequence, words MSB first.
    task automatic add_frame(input int base);
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h5A);
        exp_b.push_back(8'(FW >> 8));
        exp_b.push_back(8'(FW));
`ifdef TCP_TX_FRAMER_SEQ_EN
        for (int k = 3; k >= 0; k--) exp_b.push_back(8'(seq_m >> (8 * k)));
`endif
        for (int w = 0; w < FW; w++)
            for (int k = 3; k >= 0; k--) exp_b.push_back(8'(words[base + w] >> (8 * k)));
        seq_m++;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seq_m = 0;
        exp_frames = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; tcp_open_ack = 1'b1; tcp_tx_full = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tcp_tx_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", tcp_tx_wr); end
        checks++; if (tcp_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %h want 00", tcp_txd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL reset_abort_cnt got %0d want 0", abort_cnt); end
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) tick(0, 0);
        checks++; if (cap_b.size() != 0) begin errors++; $display("FAIL idle_quiet got %0d bytes want 0", cap_b.size()); end
    endtask

    task automatic test_basic;
        clear_cap;
        words.delete(); wptr = 0;
        words.push_back(32'h01020304);
        words.push_back(32'h05060708);
        add_frame(0);
        repeat (40) tick(1, 0);
        exp_frames++;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL basic_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++;
        if (cap_c.size() != FL || cap_c[FL-1] - cap_c[0] != FL - 1) begin
            errors++; $display("FAIL basic_consecutive got %0d bytes not back-to-back want %0d consecutive", cap_c.size(), FL);
        end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_full_stall;
        clear_cap;
        words.delete(); wptr = 0;
        words.push_back(32'h01020304);
        words.push_back(32'h05060708);
        add_frame(0);
        for (int i = 0; i < 40; i++) tick(1, (i >= HL + 4) && (i < HL + 7));
        exp_frames++;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL stall_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL stall_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++;
        if (cap_c.size() != FL || cap_c[FL-1] - cap_c[0] != FL + 2) begin
            errors++; $display("FAIL stall_gap got span %0d want %0d", (cap_c.size() == FL) ? cap_c[FL-1] - cap_c[0] : -1, FL + 2);
        end
        checks++; if (full_viol != 0) begin errors++; $display("FAIL stall_full_rule got %0d bytes under full want 0", full_viol); end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL stall_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_enable_drop;
        clear_cap;
        new_words(2 * FW);
        add_frame(0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            enable = (i < 3);
            drive(1, 0);
        end
        exp_frames++;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL endrop_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL endrop_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++; if (wptr != FW) begin errors++; $display("FAIL endrop_accepted got %0d want %0d", wptr, FW); end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL endrop_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        in_valid = 1'b0;
        words.delete(); wptr = 0;
        enable = 1'b1;
    endtask

    task automatic test_abort;
        pulse_reset;
        clear_cap;
        new_words(FW);
        add_frame(0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            tcp_open_ack = (cap_b.size() < 6);
            drive(1, 0);
        end
        checks++; if (cap_b.size() != 6) begin errors++; $display("FAIL abort_len got %0d want 6", cap_b.size()); end
        for (int j = 0; j < 6 && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL abort_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++; if (abort_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt got %0d want 1", abort_cnt); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL abort_frame_cnt got %0d want 0", frame_cnt); end
        in_valid = 1'b0;
        clear_cap;
        new_words(FW);
        add_frame(0);
        tcp_open_ack = 1'b1;
        repeat (40) tick(1, 0);
        exp_frames++;
        checks++;
        if (cap_b.size() == 0 || cap_b[0] !== 8'hA5) begin
            errors++; $display("FAIL reopen_first got %h want a5", (cap_b.size() == 0) ? 8'hxx : cap_b[0]);
        end
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL reopen_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL reopen_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL reopen_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (abort_cnt !== 16'd1) begin errors++; $display("FAIL reopen_abort_cnt got %0d want 1", abort_cnt); end
    endtask

    task automatic test_reset_mid;
        clear_cap;
        new_words(FW);
        for (int i = 0; i < 30 && cap_b.size() < HL + 3; i++) tick(1, 0);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (tcp_tx_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b want 0", tcp_tx_wr); end
        checks++; if (tcp_txd !== 8'h00) begin errors++; $display("FAIL rstmid_txd got %h want 00", tcp_txd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", in_ready); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_abort_cnt got %0d want 0", abort_cnt); end
        @(negedge clk);
        rst = 1'b0;
        seq_m = 0;
        exp_frames = 0;
        clear_cap;
        new_words(FW);
        add_frame(0);
        repeat (40) tick(1, 0);
        exp_frames++;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL rstmid_next_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL rstmid_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL rstmid_next_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_next_abort_cnt got %0d want 0", abort_cnt); end
    endtask

    task automatic test_back_to_back;
        pulse_reset;
        clear_cap;
        new_words(3 * FW);
        for (int f = 0; f < 3; f++) add_frame(f * FW);
        repeat (80) tick(1, 0);
        exp_frames += 3;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL b2b_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        for (int f = 0; f < 3 && cap_c.size() == 3 * FL; f++) begin
            checks++;
            if (cap_c[f*FL + FL - 1] - cap_c[f*FL] != FL - 1) begin
                errors++; $display("FAIL b2b_span[%0d] got %0d want %0d", f, cap_c[f*FL + FL - 1] - cap_c[f*FL], FL - 1);
            end
            if (f > 0) begin
                checks++;
                if (cap_c[f*FL] - cap_c[f*FL - 1] < 2) begin
                    errors++; $display("FAIL b2b_idle_gap[%0d] got %0d want >=2", f, cap_c[f*FL] - cap_c[f*FL - 1]);
                end
            end
        end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_random;
        clear_cap;
        new_words(20 * FW);
        for (int f = 0; f < 20; f++) add_frame(f * FW);
        for (int i = 0; i < 3000 && cap_b.size() < exp_b.size(); i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        repeat (5) tick(0, 0);
        exp_frames += 20;
        checks++; if (cap_b.size() != exp_b.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int j = 0; j < exp_b.size() && j < cap_b.size(); j++) begin
            checks++; if (cap_b[j] !== exp_b[j]) begin errors++; $display("FAIL rand_byte[%0d] got %h want %h", j, cap_b[j], exp_b[j]); end
        end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL rand_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL rand_abort_cnt got %0d want 0", abort_cnt); end
        checks++; if (full_viol != 0) begin errors++; $display("FAIL rand_full_rule got %0d bytes under full want 0", full_viol); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_stall;
        test_enable_drop;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
